// File: rtl/pipe_wb_stage_pkg.sv
// rtl/pipe_wb_stage_pkg.sv - shared state encoding and default widths for the writeback stage
package pipe_wb_stage_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_CTRL_W = 3;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } wb_state_t;
endpackage

// File: rtl/pipe_wb_stage_wb_entry_reg.sv
// rtl/pipe_wb_stage_wb_entry_reg.sv - load-enabled, reset-to-zero register for one writeback entry
module wb_entry_reg
  import pipe_wb_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CTRL_W = DEF_CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_alu_res,
  input  logic [DATA_W-1:0] i_memdata,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic              i_wen,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_alu_res,
  output logic [DATA_W-1:0] o_memdata,
  output logic [ADDR_W-1:0] o_waddr,
  output logic              o_wen
);
  always_ff @(posedge clk) begin
    if (rst) begin
      o_ctrl    <= '0;
      o_alu_res <= '0;
      o_memdata <= '0;
      o_waddr   <= '0;
      o_wen     <= 1'b0;
    end else if (i_load) begin
      o_ctrl    <= i_ctrl;
      o_alu_res <= i_alu_res;
      o_memdata <= i_memdata;
      o_waddr   <= i_waddr;
      o_wen     <= i_wen;
    end
  end
endmodule

// File: rtl/pipe_wb_stage.sv
// rtl/pipe_wb_stage.sv - two-entry registered writeback stage with forwarding outputs
module pipe_wb_stage
  import pipe_wb_stage_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int CTRL_W       = DEF_CTRL_W,
  parameter int MEMTOREG_BIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_alu_res,
  input  logic [DATA_W-1:0] in_memdata,
  input  logic [ADDR_W-1:0] in_waddr,
  input  logic              in_wen,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_alu_res,
  output logic [DATA_W-1:0] out_memdata,
  output logic [ADDR_W-1:0] out_waddr,
  output logic              out_wen,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
  output logic [1:0]        occupancy
);
  wb_state_t r_state;
  wb_state_t w_state_next;

  logic w_accept, w_pop, w_load_h, w_load_s, w_h_from_s, w_in_wen;
  logic [CTRL_W-1:0] w_s_ctrl, w_h_ctrl_d;
  logic [DATA_W-1:0] w_s_alu_res, w_s_memdata, w_h_alu_res_d, w_h_memdata_d;
  logic [ADDR_W-1:0] w_s_waddr, w_h_waddr_d;
  logic              w_s_wen, w_h_wen_d, w_h_wen;

  assign in_ready  = (r_state != ST_FULL);
  assign out_valid = (r_state != ST_EMPTY);
  assign occupancy = r_state;
  assign w_accept  = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  // Register-0 writes are dropped on entry so they never reach the forwarding net.
  assign w_in_wen  = in_wen & (in_waddr != '0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load_h     = 1'b0;
    w_load_s     = 1'b0;
    w_h_from_s   = 1'b0;
    if (flush) begin
      w_state_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_accept) begin
          w_load_h     = 1'b1;
          w_state_next = ST_ONE;
        end
        ST_ONE: begin
          if (w_accept && w_pop) begin
            w_load_h = 1'b1;
          end else if (w_accept) begin
            w_load_s     = 1'b1;
            w_state_next = ST_FULL;
          end else if (w_pop) begin
            w_state_next = ST_EMPTY;
          end
        end
        ST_FULL: if (w_pop) begin
          w_load_h     = 1'b1;
          w_h_from_s   = 1'b1;
          w_state_next = ST_ONE;
        end
        default: w_state_next = ST_EMPTY;
      endcase
    end
  end

  assign w_h_ctrl_d    = w_h_from_s ? w_s_ctrl    : in_ctrl;
  assign w_h_alu_res_d = w_h_from_s ? w_s_alu_res : in_alu_res;
  assign w_h_memdata_d = w_h_from_s ? w_s_memdata : in_memdata;
  assign w_h_waddr_d   = w_h_from_s ? w_s_waddr   : in_waddr;
  assign w_h_wen_d     = w_h_from_s ? w_s_wen     : w_in_wen;

  wb_entry_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W)) u_head (
    .clk(clk), .rst(rst), .i_load(w_load_h),
    .i_ctrl(w_h_ctrl_d), .i_alu_res(w_h_alu_res_d), .i_memdata(w_h_memdata_d),
    .i_waddr(w_h_waddr_d), .i_wen(w_h_wen_d),
    .o_ctrl(out_ctrl), .o_alu_res(out_alu_res), .o_memdata(out_memdata),
    .o_waddr(out_waddr), .o_wen(w_h_wen)
  );

  wb_entry_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W)) u_skid (
    .clk(clk), .rst(rst), .i_load(w_load_s),
    .i_ctrl(in_ctrl), .i_alu_res(in_alu_res), .i_memdata(in_memdata),
    .i_waddr(in_waddr), .i_wen(w_in_wen),
    .o_ctrl(w_s_ctrl), .o_alu_res(w_s_alu_res), .o_memdata(w_s_memdata),
    .o_waddr(w_s_waddr), .o_wen(w_s_wen)
  );

  assign out_wen   = w_h_wen & out_valid;
  assign fwd_valid = out_wen;
  assign fwd_addr  = out_waddr;
  assign fwd_data  = out_ctrl[MEMTOREG_BIT] ? out_memdata : out_alu_res;
endmodule
